// File: rtl/serial_subtractor_if.sv
// ============================================================================
//  Module      : serial_subtractor_if
//  Description : Operand/result handshake bundle for the bit-serial
//                subtractor. The slave modport is the subtractor side.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    // Operand channel
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;

    // Result channel
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;

    // Producer/consumer side
    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout
    );

    // Subtractor side
    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout
    );
endinterface

`default_nettype wire

// File: rtl/serial_subtractor.sv
// ============================================================================
//  Module      : serial_subtractor
//  Description : Bit-serial WIDTH-bit subtractor, DIFF = A - B - BIN.
//                One full-subtractor cell plus a borrow flop, LSB first,
//                with valid/ready handshakes on operands and result.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    serial_subtractor_if.slave bus,
    output logic              busy
);

    localparam int              c_CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;       // minuend, shifted right each RUN cycle
    logic [WIDTH-1:0] r_b;       // subtrahend, shifted right each RUN cycle
    logic [WIDTH-1:0] r_res;     // result bits enter from the MSB side
    logic             r_br;      // running borrow
    logic [c_CW-1:0]  r_cnt;     // bit index being processed
    logic [WIDTH-1:0] r_diff;    // published difference, held outside DONE entry
    logic             r_bout;    // published borrow out

    logic             w_d;
    logic             w_br_nxt;
    logic [WIDTH-1:0] w_res_nxt;
    logic             w_last;

    // Full-subtractor cell on the current LSBs and the running borrow
    assign w_d       = r_a[0] ^ r_b[0] ^ r_br;
    assign w_br_nxt  = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
    assign w_res_nxt = {w_d, r_res[WIDTH-1:1]};
    assign w_last    = (r_cnt == c_LAST);

    // Handshake outputs decode straight from the state so they are never
    // high together and follow the asynchronous reset immediately
    assign bus.in_ready  = (r_state == c_IDLE);
    assign bus.out_valid = (r_state == c_DONE);
    assign busy          = (r_state != c_IDLE);
    assign bus.diff      = r_diff;
    assign bus.bout      = r_bout;

    // Control FSM and serial datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_br    <= 1'b0;
            r_cnt   <= '0;
            r_diff  <= '0;
            r_bout  <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (bus.in_valid) begin
                        r_a     <= bus.a;
                        r_b     <= bus.b;
                        r_br    <= bus.bin;
                        r_cnt   <= '0;
                        r_state <= c_RUN;
                    end
                end
                c_RUN: begin
                    r_res <= w_res_nxt;
                    r_a   <= {1'b0, r_a[WIDTH-1:1]};
                    r_b   <= {1'b0, r_b[WIDTH-1:1]};
                    r_br  <= w_br_nxt;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        // The final bit is folded in here so the published
                        // result is complete on the edge entering DONE
                        r_diff  <= w_res_nxt;
                        r_bout  <= w_br_nxt;
                        r_state <= c_DONE;
                    end
                end
                c_DONE: begin
                    // New operands wait for IDLE; in_valid is ignored here
                    if (bus.out_ready) begin
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
